mem_bus_arbiter: RTL and testbench

//   Two-master, one-slave arbiter for the valid/ready memory bus. Shares one slave
//   (program ROM / RAM at 0x80000000) between master 0 (CPU) and master 1
//   (accelerator DMA). Uses round-robin grant with a registered grant, one

---
 rtl/mem_bus_arbiter_if.sv | 42 ++++
 rtl/mem_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the shared slave.
// The arbiter takes the slave modport; the environment side uses master.
interface mem_bus_arbiter_if;
  logic        m0_valid;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_wstrb;
  logic        m0_ready;
  logic [31:0] m0_rdata;

  logic        m1_valid;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wstrb;
  logic        m1_ready;
  logic [31:0] m1_rdata;

  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;

  modport slave (
    input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
    output m0_ready, m0_rdata,
    input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
    output m1_ready, m1_rdata,
    output s_valid, s_addr, s_wdata, s_wstrb,
    input  s_ready, s_rdata
  );

  modport master (
    output m0_valid, m0_addr, m0_wdata, m0_wstrb,
    input  m0_ready, m0_rdata,
    output m1_valid, m1_addr, m1_wdata, m1_wstrb,
    input  m1_ready, m1_rdata,
    input  s_valid, s_addr, s_wdata, s_wstrb,
    output s_ready, s_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for one valid/ready slave, with a registered
// grant, one transfer per grant and a slave-response timeout.
//
// state  | meaning
// IDLE   | no owner; arbitrate among pending requests
// BUSY   | granted master connected to the slave until ready/timeout/drop
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_bus_arbiter_if.slave   bus,
  input  logic               err_clr_i,
  output logic [1:0]         grant_o,
  output logic               bus_err_o,
  output logic [31:0]        err_addr_o
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bus_err_q, bus_err_d;
  logic [31:0]   err_addr_q, err_addr_d;

  logic          sel;
  logic          g_valid;
  logic [31:0]   g_addr, g_wdata;
  logic [3:0]    g_wstrb;
  logic          to_hit;
  logic          done;
  logic          timeout;
  logic [31:0]   rsp_data;

  assign sel     = grant_q[1];
  assign g_valid = sel ? bus.m1_valid : bus.m0_valid;
  assign g_addr  = sel ? bus.m1_addr  : bus.m0_addr;
  assign g_wdata = sel ? bus.m1_wdata : bus.m0_wdata;
  assign g_wstrb = sel ? bus.m1_wstrb : bus.m0_wstrb;
  assign to_hit  = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= 2'b00;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      bus_err_q  <= 1'b0;
      err_addr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      bus_err_q  <= bus_err_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    bus_err_d    = bus_err_q;
    err_addr_d   = err_addr_q;
    done         = 1'b0;
    timeout      = 1'b0;
    rsp_data     = 32'h0;
    bus.s_valid  = 1'b0;
    bus.s_addr   = 32'h0;
    bus.s_wdata  = 32'h0;
    bus.s_wstrb  = 4'h0;
    bus.m0_ready = 1'b0;
    bus.m0_rdata = 32'h0;
    bus.m1_ready = 1'b0;
    bus.m1_rdata = 32'h0;

    if (err_clr_i) begin
      bus_err_d  = 1'b0;
      err_addr_d = 32'h0;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.m0_valid || bus.m1_valid) begin
          state_d = S_BUSY;
          cnt_d   = '0;
          // last_q == 1 means m1 was served last, so m0 wins a tie
          if (bus.m0_valid && (!bus.m1_valid || last_q)) grant_d = 2'b01;
          else                                           grant_d = 2'b10;
        end
      end
      S_BUSY: begin
        if (!g_valid) begin
          state_d = S_IDLE;
          grant_d = 2'b00;
          cnt_d   = '0;
        end else begin
          bus.s_valid = !to_hit;
          bus.s_addr  = g_addr;
          bus.s_wdata = g_wdata;
          bus.s_wstrb = g_wstrb;
          if (bus.s_ready) begin
            done     = 1'b1;
            rsp_data = bus.s_rdata;
          end else if (to_hit) begin
            done     = 1'b1;
            timeout  = 1'b1;
            rsp_data = ERR_RDATA;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (done) begin
            bus.m0_ready = !sel;
            bus.m1_ready = sel;
            bus.m0_rdata = sel ? 32'h0 : rsp_data;
            bus.m1_rdata = sel ? rsp_data : 32'h0;
            last_d  = sel;
            grant_d = 2'b00;
            cnt_d   = '0;
            state_d = S_IDLE;
          end
          if (timeout) begin
            bus_err_d = 1'b1;
            if (!bus_err_q || err_clr_i) err_addr_d = g_addr;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  assign grant_o    = grant_q;
  assign bus_err_o  = bus_err_q;
  assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomised bench for mem_bus_arbiter against a transaction-level reference
// model (owner / age / last winner / sticky error) plus directed scenarios.
module tb_mem_bus_arbiter;
  localparam int          T   = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        err_clr = 1'b0;
  logic [1:0]  grant;
  logic        bus_err;
  logic [31:0] err_addr;

  mem_bus_arbiter_if bus();

  mem_bus_arbiter #(.TIMEOUT_CYCLES(T), .ERR_RDATA(ERR)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .err_clr_i(err_clr),
    .grant_o(grant), .bus_err_o(bus_err), .err_addr_o(err_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(string tag, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // master stimulus
  bit          pend [2];
  logic [31:0] a    [2];
  logic [31:0] wd   [2];
  logic [3:0]  ws   [2];
  bit          auto_m [2];
  int          issue_pct = 100;
  // slave stimulus
  bit          stall = 1'b0;
  int          min_wait = 0, max_wait = 0;
  int          slv_wait = 0, slv_cnt = 0;
  bit          rdata_fix = 1'b0;
  logic [31:0] rdata_val = 32'h0;
  // reference model
  int          own = -1;
  int          age = 0;
  int          lst = 1;
  bit          err = 1'b0;
  logic [31:0] eaddr = 32'h0;
  // observation counters
  int          sv_cycles = 0;
  int          rdy_cnt [2];
  logic [1:0]  g_prev = 2'b00;
  logic [1:0]  g_seen [$];

  task automatic model_reset();
    own = -1; age = 0; lst = 1; err = 1'b0; eaddr = 32'h0;
    pend[0] = 1'b0; pend[1] = 1'b0; slv_cnt = 0;
  endtask

  task automatic apply_masters();
    bus.m0_valid = pend[0]; bus.m0_addr = a[0]; bus.m0_wdata = wd[0]; bus.m0_wstrb = ws[0];
    bus.m1_valid = pend[1]; bus.m1_addr = a[1]; bus.m1_wdata = wd[1]; bus.m1_wstrb = ws[1];
  endtask

  task automatic gen_random();
    for (int i = 0; i < 2; i++)
      if (auto_m[i] && !pend[i] && ($urandom_range(0, 99) < issue_pct)) begin
        pend[i] = 1'b1;
        a[i]    = $urandom;
        wd[i]   = $urandom;
        ws[i]   = 4'($urandom_range(0, 15));
      end
  endtask

  // One clock cycle; entered and left at posedge + 1.
  task automatic cycle();
    bit          exp_rdy [2];
    logic [31:0] exp_rd;
    bit          exp_sv, to_now, gv, old_err, is_to;
    logic [1:0]  exp_g;
    apply_masters();
    bus.s_rdata = rdata_fix ? rdata_val : $urandom;
    #1;
    bus.s_ready = bus.s_valid && !stall && (slv_cnt >= slv_wait);
    #1;
    exp_rdy[0] = 1'b0; exp_rdy[1] = 1'b0;
    exp_rd = 32'h0; exp_sv = 1'b0; to_now = 1'b0; gv = 1'b0; is_to = 1'b0;
    exp_g = (own < 0) ? 2'b00 : ((own == 0) ? 2'b01 : 2'b10);
    check_eq("grant", 32'(grant), 32'(exp_g));
    check_eq("bus_err", 32'(bus_err), 32'(err));
    check_eq("err_addr", err_addr, eaddr);
    if (own >= 0) begin
      gv = pend[own];
      if (gv) begin
        to_now = (age == T - 1);
        exp_sv = !to_now;
        if (bus.s_ready) begin
          exp_rdy[own] = 1'b1; exp_rd = bus.s_rdata;
        end else if (to_now) begin
          exp_rdy[own] = 1'b1; exp_rd = ERR; is_to = 1'b1;
        end
      end
    end
    check_eq("s_valid", 32'(bus.s_valid), 32'(exp_sv));
    if (exp_sv) begin
      check_eq("s_addr", bus.s_addr, a[own]);
      check_eq("s_wdata", bus.s_wdata, wd[own]);
      check_eq("s_wstrb", 32'(bus.s_wstrb), 32'(ws[own]));
    end
    check_eq("m0_ready", 32'(bus.m0_ready), 32'(exp_rdy[0]));
    check_eq("m0_rdata", bus.m0_rdata, exp_rdy[0] ? exp_rd : 32'h0);
    check_eq("m1_ready", 32'(bus.m1_ready), 32'(exp_rdy[1]));
    check_eq("m1_rdata", bus.m1_rdata, exp_rdy[1] ? exp_rd : 32'h0);
    if (bus.s_valid) sv_cycles++;
    if (bus.m0_ready) rdy_cnt[0]++;
    if (bus.m1_ready) rdy_cnt[1]++;
    if (grant != 2'b00 && g_prev == 2'b00) g_seen.push_back(grant);
    g_prev = grant;
    // advance model
    old_err = err;
    if (err_clr) begin err = 1'b0; eaddr = 32'h0; end
    if (own < 0) begin
      if (pend[0] || pend[1]) begin
        own = (pend[0] && pend[1]) ? 1 - lst : (pend[0] ? 0 : 1);
        age = 0;
      end
    end else if (!gv) begin
      own = -1;
    end else if (exp_rdy[own]) begin
      if (is_to) begin
        err = 1'b1;
        if (!old_err || err_clr) eaddr = a[own];
      end
      lst = own;
      own = -1;
    end else begin
      age++;
    end
    for (int i = 0; i < 2; i++) if (exp_rdy[i]) pend[i] = 1'b0;
    if (bus.s_valid && !bus.s_ready) slv_cnt++;
    else begin
      slv_cnt  = 0;
      slv_wait = $urandom_range(min_wait, max_wait);
    end
    @(posedge clk); #1;
  endtask

  task automatic run(int n, bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd) gen_random();
      cycle();
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    apply_masters();
    bus.s_ready = 1'b0;
    #1;
    check_eq("rst_grant", 32'(grant), 32'h0);
    check_eq("rst_s_valid", 32'(bus.s_valid), 32'h0);
    check_eq("rst_m0_ready", 32'(bus.m0_ready), 32'h0);
    check_eq("rst_bus_err", 32'(bus_err), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    g_prev = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; a[i] = 32'h0; wd[i] = 32'h0; ws[i] = 4'h0;
      auto_m[i] = 1'b0; rdy_cnt[i] = 0;
    end
    bus.s_ready = 1'b0;
    bus.s_rdata = 32'h0;
    apply_masters();
    #1;
    check_eq("reset_err_addr", err_addr, 32'h0);
    @(posedge clk); #1;
    pulse_reset();

    // single zero-wait read by m0
    rdata_fix = 1'b1; rdata_val = 32'h80008137;
    pend[0] = 1'b1; a[0] = 32'h80000000; wd[0] = 32'h0; ws[0] = 4'h0;
    run(3, 1'b0);
    check_eq("t1_m0_done", 32'(rdy_cnt[0]), 32'd1);
    rdata_fix = 1'b0;

    // both masters requesting continuously from reset
    pulse_reset();
    g_seen.delete();
    auto_m[0] = 1'b1; auto_m[1] = 1'b1; issue_pct = 100;
    run(12, 1'b1);
    auto_m[0] = 1'b0; auto_m[1] = 1'b0;
    run(4, 1'b0);
    begin
      logic [1:0] exp_seq [4];
      exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
      check_eq("t2_grant_count", 32'(g_seen.size() >= 4), 32'd1);
      for (int i = 0; i < 4 && i < g_seen.size(); i++)
        check_eq($sformatf("t2_grant%0d", i), 32'(g_seen[i]), 32'(exp_seq[i]));
    end

    // m1 write with a 3-cycle wait
    sv_cycles = 0; rdy_cnt[0] = 0; rdy_cnt[1] = 0;
    min_wait = 3; max_wait = 3; slv_wait = 3;
    pend[1] = 1'b1; a[1] = 32'h10000000; wd[1] = 32'h01020304; ws[1] = 4'hF;
    run(7, 1'b0);
    check_eq("t3_s_valid_cycles", 32'(sv_cycles), 32'd4);
    check_eq("t3_m1_ready", 32'(rdy_cnt[1]), 32'd1);
    check_eq("t3_m0_ready", 32'(rdy_cnt[0]), 32'd0);
    min_wait = 0; max_wait = 0;

    // timeout, then a second timeout while sticky
    stall = 1'b1;
    pend[0] = 1'b1; a[0] = 32'h80000100; ws[0] = 4'h0;
    run(11, 1'b0);
    check_eq("t4_bus_err", 32'(bus_err), 32'd1);
    check_eq("t4_err_addr", err_addr, 32'h80000100);
    pend[0] = 1'b1; a[0] = 32'h80000200;
    run(11, 1'b0);
    check_eq("t5_err_addr_kept", err_addr, 32'h80000100);
    err_clr = 1'b1;
    run(1, 1'b0);
    err_clr = 1'b0;
    run(1, 1'b0);
    check_eq("t5_bus_err_clr", 32'(bus_err), 32'd0);
    check_eq("t5_err_addr_clr", err_addr, 32'h0);

    // reset while stalled in BUSY
    pend[0] = 1'b1; a[0] = 32'h80000300;
    run(3, 1'b0);
    pulse_reset();
    stall = 1'b0;
    pend[0] = 1'b1; pend[1] = 1'b1; a[1] = 32'h10000040;
    run(1, 1'b0);
    check_eq("t6_first_grant", 32'(grant), 32'h1);
    run(6, 1'b0);

    // randomised traffic including occasional timeouts and clears
    auto_m[0] = 1'b1; auto_m[1] = 1'b1; issue_pct = 40;
    min_wait = 0; max_wait = 10;
    for (int i = 0; i < 3000; i++) begin
      err_clr = ($urandom_range(0, 99) < 3);
      gen_random();
      cycle();
    end
    err_clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
